gray_seq_ctrl: RTL
==================

Name: gray_seq_ctrl

Overview:
- Sequencer that drives a binary count through a binary-to-Gray conversion and streams the resulting Gray codes to a consumer.
- Uses a valid/ready handshake; supports up or down counting, a load start value, one-shot or wrap mode, and abort.
- Sits in the Binary Codes area as the control front-end for Gray-code encoders, e.g. position-encoder emulation and code-table generation.

Parameters:
- WIDTH, 4, code width in bits (2..16).
- WRAP, 0, 0 = one-shot (stop at terminal count), 1 = free-run modulo 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- load  input  1  with start: 1 = begin at load_val, 0 = begin at 0 (up) or all-ones (down).
- load_val  input  WIDTH  binary start value.
- dir  input  1  0 = increment, 1 = decrement; sampled on each transfer.
- stop  input  1  abort request.
- out_ready  input  1  consumer ready.
- out_valid  output  1  gray_out/bin_out valid.
- gray_out  output  WIDTH  Gray code = bin ^ (bin >> 1).
- bin_out  output  WIDTH  current binary count.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at end of a one-shot sequence.

Behaviour:
- Reset: state=IDLE; out_valid, busy, done, gray_out, bin_out all 0. Reset asserted mid-sequence wins over every other input and discards the sequence.
- States: IDLE, RUN, DONE.
- IDLE with start=1: bin loaded (load ? load_val : dir ? all-ones : 0), then state goes to RUN. out_valid=1 on the next cycle, so latency start->first valid is 1 cycle.
- Outputs in RUN are registered: gray_out and bin_out update only on transfer (out_valid & out_ready). They are held stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer, except on stop or reset.
- On a transfer:
  - dir=0: bin+1. dir=1: bin-1.
  - Terminal count is all-ones (up) or 0 (down), evaluated with the dir sampled at that transfer.
  - Transfer of terminal with WRAP=0: state goes to DONE and out_valid drops next cycle.
  - WRAP=1: wraps modulo 2^WIDTH and never enters DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- stop=1 in RUN:
  - Goes to IDLE next cycle with out_valid=0 and no done pulse.
  - If a transfer occurs in the same cycle, the transfer completes and counts, then IDLE.
  - stop in IDLE is a no-op.
- start outside IDLE is ignored. start and stop together in IDLE: start wins.
- busy = (state==RUN).
- Arithmetic is unsigned WIDTH-bit; the Gray conversion is pure XOR with no carry.

Optional Feature:
- Macro: GRAY_SEQ_CHECK_EN.
- Defined: adds output chk_err (1 bit, reset 0).
  - On each transfer after the first of a sequence, compares the new gray_out with the previous one.
  - chk_err is sticky: it is set if the Hamming distance is not exactly 1.
  - The first transfer of a sequence never checks.
  - chk_err is cleared only by reset.
- Not defined: no port, no check logic; behaviour is otherwise identical.

Decomposition:
- Package gray_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a bin2gray function;
  - a popcount function, used by the checker.
- Natural sub-module: bin2gray_conv, a combinational WIDTH-parameterised converter instantiated once on the registered bin.

Test Plan:
- Up count, WIDTH=4, WRAP=0: start, load=0, out_ready=1.
  - Required: gray 0000,0001,0011,0010,... with bin 1101 -> gray 1011, last bin 1111 -> gray 1000.
  - Exactly 16 transfers, done pulses once, then IDLE.
- Backpressure: out_ready=0 for 3 cycles at bin 0101.
  - Required: gray_out holds 0111, out_valid stays 1, bin stays 0101.
  - On release, next value is 0110 -> gray 0101.
- Down with load: load_val=0101, dir=1.
  - Required: gray 0111, 0110, 0010, 0011, 0001, 0000 (bin 0101..0000), then done.
- Stop: stop asserted together with the transfer of bin 0011.
  - Required: that transfer counts, out_valid=0 next cycle, no done, busy=0.
  - A new start then restarts from 0000.
- Wrap (WRAP=1): load_val=1110, up.
  - Required: bin 1110, 1111, 0000, 0001 (gray 1001, 1000, 0000, 0001); no done.
- Reset mid-run at bin 1010: all outputs 0 the next cycle, state IDLE. With GRAY_SEQ_CHECK_EN, chk_err stays 0 across all scenarios above.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
package gray_pkg;

  // Widest code the helpers handle; narrower users zero-extend.
  localparam int MAXW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] popcount(input logic [MAXW-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAXW; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/bin2gray_conv.sv
// Combinational binary-to-Gray converter, WIDTH bits.
module bin2gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [MAXW-1:0] wide;
  // Upper bits of the zero-extended result are always zero.
  logic            unused_hi;

  assign wide      = bin2gray(MAXW'(bin));
  assign gray      = wide[WIDTH-1:0];
  assign unused_hi = ^wide;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code sequencer: binary counter streamed out as Gray codes over
// valid/ready. Optional sticky adjacency checker under GRAY_SEQ_CHECK_EN.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
  output logic             done
`ifdef GRAY_SEQ_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL1 = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             xfer, term, start_acc;

  assign xfer      = (state_q == RUN) && out_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign term      = dir ? (bin_q == '0) : (bin_q == ALL1);

  // State and count registers; reset discards any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
    end
  end

  // Next state and next count. A terminal one-shot transfer holds bin,
  // since no further code is presented. Stop overrides the DONE path.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    unique case (state_q)
      IDLE: if (start) begin
        bin_d   = load ? load_val : (dir ? ALL1 : '0);
        state_d = RUN;
      end
      RUN: begin
        if (xfer) begin
          if (term && (WRAP == 0)) state_d = DONE;
          else bin_d = dir ? (bin_q - ONE) : (bin_q + ONE);
        end
        if (stop) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  bin2gray_conv #(.WIDTH(WIDTH)) u_conv (
    .bin  (bin_q),
    .gray (gray_out)
  );

  assign bin_out   = bin_q;
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

`ifdef GRAY_SEQ_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             first_q;

  // Each code after the first of a sequence must differ from the
  // previous one in exactly one bit; any violation latches until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_err   <= 1'b0;
      first_q   <= 1'b1;
      prev_gray <= '0;
    end else if (start_acc) begin
      first_q <= 1'b1;
    end else if (xfer) begin
      prev_gray <= gray_out;
      first_q   <= 1'b0;
      if (!first_q && (popcount(MAXW'(gray_out ^ prev_gray)) != 5'd1))
        chk_err <= 1'b1;
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
